// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - multi-stage register pipeline with valid/ready flow control, bubble collapse and flush
module reg_pipe #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                         CP,
    input  logic                         MR,
    input  logic [WIDTH-1:0]             D,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic                         FLUSH,
    output logic [WIDTH-1:0]             Q,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [DEPTH-1:0] w_ready;
    logic             w_in_fire;
    logic [CW-1:0]    w_count;

    // A stage may advance when it is empty or anything downstream of it can move;
    // accumulated from the output side so no signal feeds back on itself.
    always_comb begin : ready_chain
        logic v_acc;
        w_ready = '0;
        v_acc   = OUT_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            v_acc      = v_acc || !r_valid[i];
            w_ready[i] = v_acc;
        end
    end

    assign IN_READY  = w_ready[0] && !FLUSH && !MR;
    assign w_in_fire = IN_VALID && IN_READY;

    // Occupancy is the number of set valid flags.
    always_comb begin : popcount
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CW'(r_valid[i]);
        end
    end

    // Stage registers: reset beats flush beats normal advance; bubbles clear valid but keep data.
    always_ff @(posedge CP) begin
        if (MR) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
            r_valid <= '0;
        end else if (FLUSH) begin
            r_valid <= '0;
        end else begin
            if (w_ready[0]) begin
                r_valid[0] <= w_in_fire;
                if (w_in_fire) begin
                    r_data[0] <= D;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
        end
    end

    assign Q         = r_data[DEPTH-1];
    assign OUT_VALID = r_valid[DEPTH-1];
    assign COUNT     = w_count;

endmodule

// File: tb/tb_reg_pipe.sv
// tb/tb_reg_pipe.sv - directed self-checking bench for reg_pipe (DEPTH=4 and DEPTH=1 instances)
module tb_reg_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic       mr, flush, in_valid, out_ready;
    logic [7:0] d;
    logic       in_ready, out_valid;
    logic [7:0] q;
    logic [2:0] count;

    // DEPTH=1 instance
    logic       mr1, flush1, in_valid1, out_ready1;
    logic [7:0] d1;
    logic       in_ready1, out_valid1;
    logic [7:0] q1;
    logic [0:0] count1;

    int n_checks = 0;
    int n_errors = 0;

    reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_dut (
        .CP(clk), .MR(mr), .D(d), .IN_VALID(in_valid), .IN_READY(in_ready),
        .FLUSH(flush), .Q(q), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .COUNT(count)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
        .CP(clk), .MR(mr1), .D(d1), .IN_VALID(in_valid1), .IN_READY(in_ready1),
        .FLUSH(flush1), .Q(q1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
        .COUNT(count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] eq, input logic ev, input logic [2:0] ec);
        check({tag, ".q"},     32'(q),         32'(eq));
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".count"}, 32'(count),     32'(ec));
    endtask

    initial begin
        mr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = 8'h00;
        mr1 = 1'b1; flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; d1 = 8'h00;
        tick();
        tick();

        // reset state
        chk_out("rst", 8'h5A, 1'b0, 3'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        mr = 1'b0;
        mr1 = 1'b0;
        #1;
        check("rst_rel.in_ready", 32'(in_ready), 32'd1);

        // streaming, latency DEPTH
        out_ready = 1'b1; in_valid = 1'b1;
        d = 8'h01; tick();
        d = 8'h02; tick();
        d = 8'h03; tick();
        chk_out("str_e3", 8'h5A, 1'b0, 3'd3);
        in_valid = 1'b0;
        tick(); chk_out("str_e4", 8'h01, 1'b1, 3'd3);
        tick(); chk_out("str_e5", 8'h02, 1'b1, 3'd2);
        tick(); chk_out("str_e6", 8'h03, 1'b1, 3'd1);
        tick(); chk_out("str_e7", 8'h03, 1'b0, 3'd0);

        // back-pressure
        out_ready = 1'b0; in_valid = 1'b1;
        d = 8'hA0; tick();
        d = 8'hA1; tick();
        d = 8'hA2; tick();
        d = 8'hA3; tick();
        chk_out("bp_full", 8'hA0, 1'b1, 3'd4);
        d = 8'hA4; #1;
        check("bp_full.in_ready", 32'(in_ready), 32'd0);
        tick(); chk_out("bp_hold", 8'hA0, 1'b1, 3'd4);
        out_ready = 1'b1; #1;
        check("bp_pass.in_ready", 32'(in_ready), 32'd1);
        tick(); chk_out("bp_o1", 8'hA1, 1'b1, 3'd4);
        d = 8'hA5; tick(); chk_out("bp_o2", 8'hA2, 1'b1, 3'd4);
        in_valid = 1'b0;
        tick(); chk_out("bp_o3", 8'hA3, 1'b1, 3'd3);
        tick(); chk_out("bp_o4", 8'hA4, 1'b1, 3'd2);
        tick(); chk_out("bp_o5", 8'hA5, 1'b1, 3'd1);
        tick(); chk_out("bp_empty", 8'hA5, 1'b0, 3'd0);

        // bubble collapse under back-pressure
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'h11; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; d = 8'h22; tick();
        in_valid = 1'b0;
        chk_out("bub_e4", 8'h11, 1'b1, 3'd2);
        tick(); tick();
        chk_out("bub_e6", 8'h11, 1'b1, 3'd2);
        out_ready = 1'b1;
        tick(); chk_out("bub_adj", 8'h22, 1'b1, 3'd1);
        tick(); chk_out("bub_done", 8'h22, 1'b0, 3'd0);

        // flush with input offered
        out_ready = 1'b0; in_valid = 1'b1;
        d = 8'h31; tick();
        d = 8'h32; tick();
        d = 8'h33; tick();
        chk_out("fl_pre", 8'h22, 1'b0, 3'd3);
        flush = 1'b1; d = 8'h55; #1;
        check("fl.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_out("fl_post", 8'h22, 1'b0, 3'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fl_no55.valid", 32'(out_valid), 32'd0);
        end

        // reset mid-stream, overriding flush
        out_ready = 1'b0; in_valid = 1'b1;
        d = 8'h41; tick();
        d = 8'h42; tick();
        check("mr_pre.count", 32'(count), 32'd2);
        mr = 1'b1; flush = 1'b1; d = 8'h77; #1;
        check("mr.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_out("mr_post", 8'h5A, 1'b0, 3'd0);
        check("mr_post.in_ready", 32'(in_ready), 32'd0);
        mr = 1'b0; flush = 1'b0; in_valid = 1'b0; #1;
        check("mr_rel.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mr_drain.valid", 32'(out_valid), 32'd0);
        end

        // DEPTH=1 single register
        in_valid1 = 1'b1; d1 = 8'h01; out_ready1 = 1'b0; #1;
        check("d1_a.in_ready", 32'(in_ready1), 32'd1);
        tick();
        check("d1_a.q", 32'(q1), 32'h01);
        check("d1_a.valid", 32'(out_valid1), 32'd1);
        check("d1_a.count", 32'(count1), 32'd1);
        d1 = 8'h02; #1;
        check("d1_b.in_ready", 32'(in_ready1), 32'd0);
        tick();
        check("d1_b.q", 32'(q1), 32'h01);
        out_ready1 = 1'b1; #1;
        check("d1_c.in_ready", 32'(in_ready1), 32'd1);
        tick();
        check("d1_c.q", 32'(q1), 32'h02);
        check("d1_c.valid", 32'(out_valid1), 32'd1);
        in_valid1 = 1'b0; out_ready1 = 1'b0; #1;
        check("d1_d.in_ready", 32'(in_ready1), 32'd0);
        tick();
        check("d1_d.q", 32'(q1), 32'h02);
        check("d1_d.valid", 32'(out_valid1), 32'd1);
        out_ready1 = 1'b1; #1;
        check("d1_e.in_ready", 32'(in_ready1), 32'd1);
        tick();
        check("d1_e.valid", 32'(out_valid1), 32'd0);
        check("d1_e.count", 32'(count1), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0 (WIDTH bits), meaning data value loaded into every stage on reset.
REQ-004 SHALL have port CP  input  1  clock; all state changes on rising edge only.
REQ-005 SHALL have port MR  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port D  input  WIDTH  input data.
REQ-007 SHALL have port IN_VALID  input  1  D holds an item to load.
REQ-008 SHALL have port IN_READY  output  1  pipe accepts an item this cycle.
REQ-009 SHALL have port FLUSH  input  1  synchronous discard of all held items.
REQ-010 SHALL have port Q  output  WIDTH  data of the last stage (stage DEPTH-1).
REQ-011 SHALL have port OUT_VALID  output  1  last stage holds a valid item.
REQ-012 SHALL have port OUT_READY  input  1  consumer takes Q this cycle.
REQ-013 SHALL have port COUNT  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 SHALL hold per stage i (0..DEPTH-1) a data register data[i] and a flag valid[i]; stage 0 is input side.
REQ-015 SHALL define ready[DEPTH] = OUT_READY and ready[i] = !valid[i] || ready[i+1], combinationally.
REQ-016 SHALL drive IN_READY = ready[0] && !FLUSH && !MR.
REQ-017 SHALL, for i>0 when ready[i]: load data[i] <= data[i-1] and valid[i] <= valid[i-1]; when !ready[i], hold stage i.
REQ-018 SHALL, when ready[0]: load data[0] <= D and valid[0] <= IN_VALID && IN_READY; else hold stage 0.
REQ-019 SHALL load data[i] only when the moved-in valid bit is 1; a bubble moving in clears valid[i] but leaves data[i] unchanged.
REQ-020 SHALL count a transfer out when OUT_VALID && OUT_READY and a transfer in when IN_VALID && IN_READY.
REQ-021 SHALL drive Q = data[DEPTH-1] and OUT_VALID = valid[DEPTH-1] directly from registers (no combinational path from D).
REQ-022 SHALL present an item accepted at edge k as OUT_VALID=1, Q=item from edge k+DEPTH-1 onward when OUT_READY held high (latency DEPTH cycles, throughput one item per cycle).
REQ-023 SHALL collapse bubbles: an invalid stage accepts from its predecessor even while OUT_READY=0.
REQ-024 SHALL never drop or duplicate a valid item; order out equals order in.
REQ-025 SHALL drive COUNT = popcount(valid) from registered state.
REQ-026 SHALL, when FLUSH=1 at an edge, clear all valid[i], leave data[i] unchanged, accept no input; the outgoing transfer in that cycle (OUT_VALID && OUT_READY) still counts as delivered.
REQ-027 SHALL, when full (COUNT=DEPTH) and OUT_READY=1, accept a new input in the same cycle (IN_READY=1).
REQ-028 SHALL, when full and OUT_READY=0, drive IN_READY=0 and hold all stages.
REQ-029 SHALL, for DEPTH=1, behave as a single register with valid/ready: IN_READY = !OUT_VALID || OUT_READY.

Reset
REQ-030 SHALL, when MR=1 at a rising edge of CP, set every data[i] <= RESET_VAL and every valid[i] <= 0, overriding FLUSH and any transfer.
REQ-031 SHALL present after reset: Q=RESET_VAL, OUT_VALID=0, COUNT=0; IN_READY=0 while MR=1, =1 the cycle after MR falls.
REQ-032 SHALL apply reset mid-operation identically: all in-flight items discarded, none delivered after the reset edge.

Verification
REQ-033 SHALL cover streaming: WIDTH=8, DEPTH=4, OUT_READY=1, IN_VALID=1, D=0x01,0x02,0x03 on consecutive edges -> Q=0x01,0x02,0x03 with OUT_VALID=1 from edge 4 after first acceptance, COUNT stays <=4.
REQ-034 SHALL cover back-pressure: OUT_READY=0, push 0xA0..0xA5 -> IN_READY falls after 4 accepted (COUNT=4, Q=0xA0); raise OUT_READY -> 0xA0..0xA3 out in order, then 0xA4 accepted same cycle as 0xA0 leaves.
REQ-035 SHALL cover bubble collapse: push 0x11, idle 2 cycles, push 0x22 with OUT_READY=0 -> COUNT=2 and Q=0x11 after 4 edges, 0x22 adjacent in stage DEPTH-2.
REQ-036 SHALL cover flush: COUNT=3, FLUSH=1 with IN_VALID=1, D=0x55 -> next cycle COUNT=0, OUT_VALID=0, 0x55 never emitted, Q unchanged.
REQ-037 SHALL cover reset mid-stream with RESET_VAL=0x5A: MR=1 while COUNT=2 and FLUSH=1 -> Q=0x5A, OUT_VALID=0, COUNT=0, IN_READY=0 during MR, 1 the cycle after.
REQ-038 SHALL cover DEPTH=1: alternating OUT_READY -> items 0x01,0x02 delivered once each, IN_READY = !OUT_VALID || OUT_READY every cycle.
